bit_incrementer_counter: RTL and testbench
==========================================

# bit_incrementer_counter

Parameterized synchronous up-counter built around an increment-by-one datapath, the counting counterpart of the team's four-bit decrementer. It loads a start value, increments on enable until it reaches a programmed limit, then signals completion. It wraps modulo 2^WIDTH and flags each all-ones-to-zero rollover with a one-cycle carry pulse. It sits in the chapter-4 arithmetic exercise set as the first sequential incrementer block and is self-checked by its own testbench.

## Interface
- WIDTH, 4, counter and data width in bits (≥2)
- clk  input  1  rising-edge clock; sole clock
- reset_b  input  1  asynchronous, active-low reset
- start  input  1  load din and begin counting (accepted in any state)
- din  input  WIDTH  start value, sampled on the edge where start=1
- limit  input  WIDTH  terminal value; sampled continuously while RUN
- inc  input  1  increment enable, honoured only in RUN
- count  output  WIDTH  registered counter value
- c  output  1  registered carry; 1 for exactly one cycle after count wraps from all-ones to 0
- busy  output  1  registered; 1 while state is RUN
- done  output  1  registered; 1 while state is DONE

## Operation
- States: IDLE (reset state), RUN, DONE; 2-bit encoding, unused code returns to IDLE.
- Reset (reset_b=0, asynchronous): count=0, c=0, busy=0, done=0, state=IDLE; held until reset_b rises; first action on the next rising edge.
- Priority each edge: start > limit check > inc.
- Any state, start=1: count<=din, c<=0, state<=RUN. This includes a restart mid-RUN, which discards the current count, and a restart from DONE.
- IDLE, start=0: hold count; c<=0.
- RUN, start=0:
  - If count==limit: state<=DONE, count held, c<=0. The increment is suppressed on this edge even if inc=1.
  - Else if inc=1: count<=count+1 modulo 2^WIDTH. c<=1 iff the old count was all ones, else c<=0.
  - Else: hold count; c<=0.
- DONE, start=0: hold count and done; c<=0. The only exits are start or reset.
- Arithmetic: a WIDTH-bit add of 1, computed at WIDTH+1 bits. The MSB of the sum is the carry source; the lower WIDTH bits are the next count. No saturation.
- din==limit: the counter enters RUN, and the next edge goes to DONE with zero increments.
- limit below din: the count wraps through 0 and then reaches limit. c pulses once per wrap.
- limit changed mid-RUN: the comparison uses the current value on each edge.
- inc=0 in RUN: counting pauses, busy stays 1, and the limit check still runs.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Start latency: start sampled at edge k gives count=din and busy=1 after edge k.
- With inc held at 1, done rises after edge k + (limit − din mod 2^WIDTH) + 1, and busy falls on the same edge.
- c is high during the single cycle in which count=0 following a wrap. It is low in every other cycle.
- reset_b asserted mid-RUN clears all outputs immediately, without waiting for a clock edge.

## Test plan
- Reset then idle: reset_b=0 for 2 cycles, then release with start=0 and inc=1 for 5 cycles -> count=0, c=0, busy=0, done=0 throughout.
- Basic run (WIDTH=4): start with din=3 and limit=6, inc=1 -> count 3,4,5,6. done=1 on the 4th edge after load, busy falls on the same edge, c never set, count then holds at 6 for 3 cycles.
- Wrap: din=14, limit=1, inc=1 -> count 14,15,0,1. c=1 only in the cycle where count=0, then done=1.
- Pause and immediate done: din=5, limit=8, inc toggled 1,0,0,1,1 -> count 5,6,6,6,7,8, then done. Separately, din=limit=9 -> done on the first edge after load with count=9.
- Restart and async reset: din=2, limit=12, inc=1. After count=5, pulse start with din=10 -> count=10, busy stays 1, done at 12. Then start with din=0, limit=15, and assert reset_b=0 between edges at count=4 -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/bit_incrementer_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_incrementer_counter: loadable up-counter that runs to a limit,   |
// | with a one-cycle carry pulse on each rollover.    Rev 1.0            |
// +----------------------------------------------------------------------+
module bit_incrementer_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             c,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;

  // Sum is one bit wider so its MSB is the rollover carry.
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      count   <= '0;
      c       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      c <= 1'b0;
      if (start) begin
        r_state <= S_RUN;
        count   <= din;
        busy    <= 1'b1;
        done    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_RUN: begin
            // Limit check wins over increment on the same edge.
            if (count == limit) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (inc) begin
              count <= w_sum[WIDTH-1:0];
              c     <= w_sum[WIDTH];
            end
          end
          S_DONE: ;
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_incrementer_counter.sv
`default_nettype none
// Directed self-checking bench for bit_incrementer_counter (WIDTH=4).
module tb_bit_incrementer_counter;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       start;
  logic [3:0] din;
  logic [3:0] limit;
  logic       inc;
  logic [3:0] count;
  logic       c;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  bit_incrementer_counter #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (start),
    .din     (din),
    .limit   (limit),
    .inc     (inc),
    .count   (count),
    .c       (c),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Expected vectors are packed as {count, c, busy, done}.
  task automatic test_reset();
    reset_b = 1'b0; start = 1'b0; inc = 1'b1; din = 4'd0; limit = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({count, c, busy, done} !== 7'b0000_000) begin
      n_err++;
      $display("FAIL reset_held: got count=%0d c=%b busy=%b done=%b, want all 0", count, c, busy, done);
    end
    reset_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({count, c, busy, done} !== 7'b0000_000) begin
        n_err++;
        $display("FAIL idle[%0d]: got count=%0d c=%b busy=%b done=%b, want all 0", i, count, c, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] exp [8];
    exp = '{{4'd3, 3'b010}, {4'd4, 3'b010}, {4'd5, 3'b010}, {4'd6, 3'b010},
            {4'd6, 3'b001}, {4'd6, 3'b001}, {4'd6, 3'b001}, {4'd6, 3'b001}};
    din = 4'd3; limit = 4'd6; inc = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if ({count, c, busy, done} !== exp[i]) begin
        n_err++;
        $display("FAIL basic[%0d]: got count=%0d c=%b busy=%b done=%b, want count=%0d c/busy/done=%b",
                 i, count, c, busy, done, exp[i][6:3], exp[i][2:0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [6:0] exp [5];
    exp = '{{4'd14, 3'b010}, {4'd15, 3'b010}, {4'd0, 3'b110}, {4'd1, 3'b010}, {4'd1, 3'b001}};
    din = 4'd14; limit = 4'd1; inc = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if ({count, c, busy, done} !== exp[i]) begin
        n_err++;
        $display("FAIL wrap[%0d]: got count=%0d c=%b busy=%b done=%b, want count=%0d c/busy/done=%b",
                 i, count, c, busy, done, exp[i][6:3], exp[i][2:0]);
      end
    end
  endtask

  task automatic test_pause();
    logic [6:0] exp [7];
    logic       iv  [7];
    exp = '{{4'd5, 3'b010}, {4'd6, 3'b010}, {4'd6, 3'b010}, {4'd6, 3'b010},
            {4'd7, 3'b010}, {4'd8, 3'b010}, {4'd8, 3'b001}};
    // inc value presented for the edge that follows each sample
    iv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    din = 4'd5; limit = 4'd8; inc = 1'b0; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      inc   = iv[i];
      n_cmp++;
      if ({count, c, busy, done} !== exp[i]) begin
        n_err++;
        $display("FAIL pause[%0d]: got count=%0d c=%b busy=%b done=%b, want count=%0d c/busy/done=%b",
                 i, count, c, busy, done, exp[i][6:3], exp[i][2:0]);
      end
    end
  endtask

  task automatic test_immediate_done();
    din = 4'd9; limit = 4'd9; inc = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({count, c, busy, done} !== {4'd9, 3'b010}) begin
      n_err++;
      $display("FAIL imm_load: got count=%0d c=%b busy=%b done=%b, want count=9 busy=1", count, c, busy, done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({count, c, busy, done} !== {4'd9, 3'b001}) begin
      n_err++;
      $display("FAIL imm_done: got count=%0d c=%b busy=%b done=%b, want count=9 done=1", count, c, busy, done);
    end
  endtask

  task automatic test_restart_reset();
    logic [6:0] exp [8];
    logic       st  [8];
    exp = '{{4'd2, 3'b010}, {4'd3, 3'b010}, {4'd4, 3'b010}, {4'd5, 3'b010},
            {4'd10, 3'b010}, {4'd11, 3'b010}, {4'd12, 3'b010}, {4'd12, 3'b001}};
    st  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    din = 4'd2; limit = 4'd12; inc = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start = st[i];
      din   = st[i] ? 4'd10 : din;
      n_cmp++;
      if ({count, c, busy, done} !== exp[i]) begin
        n_err++;
        $display("FAIL restart[%0d]: got count=%0d c=%b busy=%b done=%b, want count=%0d c/busy/done=%b",
                 i, count, c, busy, done, exp[i][6:3], exp[i][2:0]);
      end
    end
    // Restart out of DONE, then reset asynchronously mid-run.
    din = 4'd0; limit = 4'd15; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if ({count, c, busy, done} !== {i[3:0], 3'b010}) begin
        n_err++;
        $display("FAIL rerun[%0d]: got count=%0d c=%b busy=%b done=%b, want count=%0d busy=1", i, count, c, busy, done, i);
      end
    end
    #2 reset_b = 1'b0;
    #1;
    n_cmp++;
    if ({count, c, busy, done} !== 7'b0000_000) begin
      n_err++;
      $display("FAIL async_reset: got count=%0d c=%b busy=%b done=%b, want all 0", count, c, busy, done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({count, c, busy, done} !== 7'b0000_000) begin
      n_err++;
      $display("FAIL reset_hold: got count=%0d c=%b busy=%b done=%b, want all 0", count, c, busy, done);
    end
    reset_b = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({count, c, busy, done} !== 7'b0000_000) begin
      n_err++;
      $display("FAIL post_reset_idle: got count=%0d c=%b busy=%b done=%b, want all 0", count, c, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_pause();
    test_immediate_done();
    test_restart_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
